// File: rtl/is_sched_queue_pkg.sv
// ============================================================================
// Module  : is_pkg
// Brief   : Shared widths and the scheduler-queue entry record.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package is_pkg;

    localparam int c_ENTRIES    = 16;
    localparam int c_DISPATCH_W = 2;
    localparam int c_ISSUE_W    = 2;
    localparam int c_WAKEUP_W   = 2;
    localparam int c_TAG_W      = 6;
    localparam int c_ROB_W      = 5;
    localparam int c_UOP_W      = 32;
    localparam int c_NUM_SRC    = 2;

    typedef struct packed {
        logic                                valid;
        logic [c_UOP_W-1:0]                  uop;
        logic [c_ROB_W-1:0]                  rob;
        logic [c_TAG_W-1:0]                  dest;
        logic [c_NUM_SRC-1:0][c_TAG_W-1:0]   src;
        logic [c_NUM_SRC-1:0]                src_rdy;
    } is_sq_entry;

endpackage

`default_nettype wire

// File: rtl/is_sched_queue_if.sv
// ============================================================================
// Module  : is_sched_queue_if
// Brief   : Dispatch, wakeup-broadcast and issue bundle of the scheduler queue.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface is_sched_queue_if
    import is_pkg::*;
#(
    parameter int DISPATCH_W = c_DISPATCH_W,
    parameter int ISSUE_W    = c_ISSUE_W,
    parameter int WAKEUP_W   = c_WAKEUP_W,
    parameter int TAG_W      = c_TAG_W,
    parameter int ROB_W      = c_ROB_W,
    parameter int UOP_W      = c_UOP_W
) ();

    logic [DISPATCH_W-1:0]               disp_valid_in;
    logic                                disp_ready_out;
    logic [DISPATCH_W*UOP_W-1:0]         disp_uop_in;
    logic [DISPATCH_W*ROB_W-1:0]         disp_rob_in;
    logic [DISPATCH_W*TAG_W-1:0]         disp_dest_in;
    logic [DISPATCH_W*c_NUM_SRC*TAG_W-1:0] disp_src_in;
    logic [DISPATCH_W*c_NUM_SRC-1:0]     disp_src_rdy_in;

    logic [WAKEUP_W-1:0]                 wk_valid_in;
    logic [WAKEUP_W*TAG_W-1:0]           wk_tag_in;

    logic [ISSUE_W-1:0]                  iss_valid_out;
    logic [ISSUE_W-1:0]                  iss_ready_in;
    logic [ISSUE_W*UOP_W-1:0]            iss_uop_out;
    logic [ISSUE_W*ROB_W-1:0]            iss_rob_out;
    logic [ISSUE_W*TAG_W-1:0]            iss_dest_out;

    modport master (
        output disp_valid_in, disp_uop_in, disp_rob_in, disp_dest_in,
               disp_src_in, disp_src_rdy_in,
        input  disp_ready_out,
        output wk_valid_in, wk_tag_in,
        input  iss_valid_out, iss_uop_out, iss_rob_out, iss_dest_out,
        output iss_ready_in
    );

    modport slave (
        input  disp_valid_in, disp_uop_in, disp_rob_in, disp_dest_in,
               disp_src_in, disp_src_rdy_in,
        output disp_ready_out,
        input  wk_valid_in, wk_tag_in,
        output iss_valid_out, iss_uop_out, iss_rob_out, iss_dest_out,
        input  iss_ready_in
    );

endinterface

`default_nettype wire

// File: rtl/is_sched_queue_age_matrix.sv
// ============================================================================
// Module  : is_age_matrix
// Brief   : Relative-age matrix with oldest-k select; bit [i][j] = i older than j.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module is_age_matrix #(
    parameter int ENTRIES = 16,
    parameter int ISSUE_W = 2,
    parameter int SLOT_W  = 1
) (
    input  wire logic                              clk,
    input  wire logic                              rst,
    input  wire logic                              i_clear,
    input  wire logic [ENTRIES-1:0]                i_valid,
    input  wire logic [ENTRIES-1:0]                i_alloc_en,
    input  wire logic [ENTRIES-1:0][SLOT_W-1:0]    i_alloc_slot,
    input  wire logic [ENTRIES-1:0]                i_free_en,
    input  wire logic [ENTRIES-1:0]                i_req,
    output logic      [ISSUE_W-1:0][ENTRIES-1:0]   o_grant
);

    localparam int c_RANK_W = $clog2(ENTRIES) + 1;

    logic [ENTRIES-1:0][ENTRIES-1:0] r_older;
    logic [ENTRIES-1:0][c_RANK_W-1:0] w_rank;

    // A new entry is younger than every survivor and than lower dispatch slots.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_older <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                for (int j = 0; j < ENTRIES; j++) begin
                    if (i_alloc_en[j]) begin
                        r_older[i][j] <= (i_valid[i] && !i_free_en[i]) ||
                                         (i_alloc_en[i] && (i_alloc_slot[i] < i_alloc_slot[j]));
                    end else if (i_alloc_en[i] || i_free_en[i] || i_free_en[j]) begin
                        r_older[i][j] <= 1'b0;
                    end
                end
            end
        end
    end

    // Rank = number of requesting entries older than this one; port p takes rank p.
    always_comb begin
        w_rank  = '0;
        o_grant = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            for (int j = 0; j < ENTRIES; j++) begin
                if (i_req[j] && r_older[j][i]) begin
                    w_rank[i] = w_rank[i] + c_RANK_W'(1);
                end
            end
        end
        for (int p = 0; p < ISSUE_W; p++) begin
            for (int i = 0; i < ENTRIES; i++) begin
                o_grant[p][i] = i_req[i] && (w_rank[i] == c_RANK_W'(p));
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/is_sched_queue.sv
// ============================================================================
// Module  : is_sched_queue
// Brief   : Out-of-order scheduler queue: dispatch, tag wakeup, oldest-first issue.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module is_sched_queue
    import is_pkg::*;
#(
    parameter int ENTRIES    = c_ENTRIES,
    parameter int DISPATCH_W = c_DISPATCH_W,
    parameter int ISSUE_W    = c_ISSUE_W,
    parameter int WAKEUP_W   = c_WAKEUP_W,
    parameter int TAG_W      = c_TAG_W,
    parameter int ROB_W      = c_ROB_W,
    parameter int UOP_W      = c_UOP_W
) (
    input  wire logic                    clk_in,
    input  wire logic                    rst_in,
    input  wire logic                    flush_in,
    is_sched_queue_if.slave              bus,
    output logic [$clog2(ENTRIES):0]     count_out
);

    localparam int c_CNT_W  = $clog2(ENTRIES) + 1;
    localparam int c_SLOT_W = (DISPATCH_W > 1) ? $clog2(DISPATCH_W) : 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH  = c_CNT_W'(ENTRIES);
    localparam logic [c_CNT_W-1:0] c_DISP_N = c_CNT_W'(DISPATCH_W);

    is_sq_entry                      r_q [ENTRIES];
    logic [c_CNT_W-1:0]              r_count;

    logic                            w_kill;
    logic                            w_disp_ready;
    logic [DISPATCH_W-1:0]           w_disp_fire;
    logic [ENTRIES-1:0]              w_valid;
    logic [ENTRIES-1:0]              w_cand;
    logic [ENTRIES-1:0]              w_alloc_en;
    logic [ENTRIES-1:0][c_SLOT_W-1:0] w_alloc_slot;
    logic [ENTRIES-1:0]              w_free_en;
    is_sq_entry                      w_new   [DISPATCH_W];
    is_sq_entry                      w_woken [ENTRIES];
    logic [ISSUE_W-1:0][ENTRIES-1:0] w_grant;
    logic [ISSUE_W-1:0]              w_iss_valid;
    logic [ISSUE_W-1:0]              w_iss_fire;
    logic [c_CNT_W-1:0]              w_n_disp;
    logic [c_CNT_W-1:0]              w_n_iss;
    logic [c_CNT_W:0]                w_next_wide;

    function automatic logic f_wake_hit(
        input logic [TAG_W-1:0]          tag,
        input logic [WAKEUP_W-1:0]       vld,
        input logic [WAKEUP_W*TAG_W-1:0] tags
    );
        f_wake_hit = 1'b0;
        for (int w = 0; w < WAKEUP_W; w++) begin
            if (vld[w] && (tags[w*TAG_W +: TAG_W] == tag)) begin
                f_wake_hit = 1'b1;
            end
        end
    endfunction

    assign w_kill       = rst_in || flush_in;
    assign w_disp_ready = !w_kill && ((c_DEPTH - r_count) >= c_DISP_N);
    assign w_disp_fire  = bus.disp_valid_in & {DISPATCH_W{w_disp_ready}};

    assign bus.disp_ready_out = w_disp_ready;
    assign bus.iss_valid_out  = w_iss_valid;
    assign count_out          = rst_in ? '0 : r_count;

    always_comb begin
        for (int e = 0; e < ENTRIES; e++) begin
            w_valid[e] = r_q[e].valid;
            w_cand[e]  = r_q[e].valid && (&r_q[e].src_rdy);
        end
    end

    // Lowest free entries go to active slots in slot order.
    always_comb begin
        logic [DISPATCH_W-1:0] w_pending;
        logic                  w_taken;
        w_pending    = w_disp_fire;
        w_taken      = 1'b0;
        w_alloc_en   = '0;
        w_alloc_slot = '0;
        for (int e = 0; e < ENTRIES; e++) begin
            if (!r_q[e].valid) begin
                w_taken = 1'b0;
                for (int s = 0; s < DISPATCH_W; s++) begin
                    if (w_pending[s] && !w_taken) begin
                        w_alloc_en[e]   = 1'b1;
                        w_alloc_slot[e] = c_SLOT_W'(s);
                        w_pending[s]    = 1'b0;
                        w_taken         = 1'b1;
                    end
                end
            end
        end
    end

    // New uops see same-cycle broadcasts so a bypassed source lands ready.
    always_comb begin
        for (int s = 0; s < DISPATCH_W; s++) begin
            w_new[s].valid = 1'b1;
            w_new[s].uop   = bus.disp_uop_in[s*UOP_W +: UOP_W];
            w_new[s].rob   = bus.disp_rob_in[s*ROB_W +: ROB_W];
            w_new[s].dest  = bus.disp_dest_in[s*TAG_W +: TAG_W];
            for (int k = 0; k < c_NUM_SRC; k++) begin
                w_new[s].src[k]     = bus.disp_src_in[(s*c_NUM_SRC+k)*TAG_W +: TAG_W];
                w_new[s].src_rdy[k] = bus.disp_src_rdy_in[s*c_NUM_SRC+k] ||
                                      f_wake_hit(bus.disp_src_in[(s*c_NUM_SRC+k)*TAG_W +: TAG_W],
                                                 bus.wk_valid_in, bus.wk_tag_in);
            end
        end
        for (int e = 0; e < ENTRIES; e++) begin
            w_woken[e] = r_q[e];
            for (int k = 0; k < c_NUM_SRC; k++) begin
                if (f_wake_hit(r_q[e].src[k], bus.wk_valid_in, bus.wk_tag_in)) begin
                    w_woken[e].src_rdy[k] = 1'b1;
                end
            end
        end
    end

    is_age_matrix #(
        .ENTRIES (ENTRIES),
        .ISSUE_W (ISSUE_W),
        .SLOT_W  (c_SLOT_W)
    ) u_age (
        .clk          (clk_in),
        .rst          (rst_in),
        .i_clear      (flush_in),
        .i_valid      (w_valid),
        .i_alloc_en   (w_alloc_en),
        .i_alloc_slot (w_alloc_slot),
        .i_free_en    (w_free_en),
        .i_req        (w_cand),
        .o_grant      (w_grant)
    );

    always_comb begin
        bus.iss_uop_out  = '0;
        bus.iss_rob_out  = '0;
        bus.iss_dest_out = '0;
        w_free_en        = '0;
        for (int p = 0; p < ISSUE_W; p++) begin
            w_iss_valid[p] = (|w_grant[p]) && !w_kill;
            for (int e = 0; e < ENTRIES; e++) begin
                if (w_grant[p][e]) begin
                    bus.iss_uop_out[p*UOP_W +: UOP_W]  = r_q[e].uop;
                    bus.iss_rob_out[p*ROB_W +: ROB_W]  = r_q[e].rob;
                    bus.iss_dest_out[p*TAG_W +: TAG_W] = r_q[e].dest;
                end
            end
        end
        w_iss_fire = w_iss_valid & bus.iss_ready_in;
        for (int p = 0; p < ISSUE_W; p++) begin
            if (w_iss_fire[p]) begin
                w_free_en = w_free_en | w_grant[p];
            end
        end
    end

    always_comb begin
        w_n_disp = '0;
        w_n_iss  = '0;
        for (int s = 0; s < DISPATCH_W; s++) begin
            if (w_disp_fire[s]) w_n_disp = w_n_disp + c_CNT_W'(1);
        end
        for (int p = 0; p < ISSUE_W; p++) begin
            if (w_iss_fire[p]) w_n_iss = w_n_iss + c_CNT_W'(1);
        end
        w_next_wide = {1'b0, r_count} + {1'b0, w_n_disp} - {1'b0, w_n_iss};
    end

    always_ff @(posedge clk_in) begin
        if (w_kill) begin
            for (int e = 0; e < ENTRIES; e++) begin
                r_q[e] <= '0;
            end
            r_count <= '0;
        end else begin
            assert (!w_next_wide[c_CNT_W] && (w_next_wide[c_CNT_W-1:0] <= c_DEPTH));
            for (int e = 0; e < ENTRIES; e++) begin
                if (w_alloc_en[e]) begin
                    r_q[e] <= w_new[w_alloc_slot[e]];
                end else if (w_free_en[e]) begin
                    r_q[e].valid <= 1'b0;
                end else begin
                    r_q[e] <= w_woken[e];
                end
            end
            r_count <= w_next_wide[c_CNT_W-1:0];
        end
    end

endmodule

`default_nettype wire
